// File: rtl/m68k_bus_target.sv
// 68000 asynchronous-bus target: synchronises the bus strobes into PI_CLK, decodes a window,
// forwards one local request per bus cycle and answers with DTACK (ack) or BERR (timeout).
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR = 24'hDE0000,
  parameter logic [23:0] ADDR_MASK = 24'hFF0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        PI_CLK,
  input  logic        RESET_n,
  input  logic        M68K_CLK,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [2:0]  M68K_FC,
  input  logic [22:0] M68K_A,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        LOC_REQ,
  output logic        LOC_WE,
  output logic [22:0] LOC_ADDR,
  output logic [1:0]  LOC_BE,
  output logic [15:0] LOC_WDATA,
  input  logic [15:0] LOC_RDATA,
  input  logic        LOC_ACK,
  output logic [2:0]  dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_BERR   = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mclk_sync_q, as_sync_q, uds_sync_q, lds_sync_q;
  logic [1:0]    vld_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q;
  logic          loc_req_q, loc_we_q;
  logic [22:0]   loc_addr_q;
  logic [1:0]    loc_be_q;
  logic [15:0]   loc_wdata_q, d_out_q;
  logic          d_oe_q, dtack_n_q, berr_n_q;

  logic as_n, ds_low, hit, mclk_fall, expire, issue;

  // Stage 1 is bit 0 (newest sample), stage 2 is bit 1.
  assign as_n      = as_sync_q[1];
  assign ds_low    = ~uds_sync_q[1] | ~lds_sync_q[1];
  assign mclk_fall = mclk_sync_q[1] & ~mclk_sync_q[0];
  assign expire    = mclk_fall && (cnt_q == CW'(TIMEOUT - 1));
  assign hit       = (({M68K_A, 1'b0} & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) &&
                     (M68K_FC != 3'b111);

  // armed_q demands a genuine high AS sample (synchroniser refilled after reset) before
  // any cycle is accepted, so an AS held low through reset is never taken as a new cycle.
  assign armed_d = armed_q | (vld_q[1] & as_sync_q[1]);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE:   if (armed_q && !as_n) state_d = S_DECODE;
      S_DECODE: begin
        if (as_n)         state_d = S_IDLE;
        else if (!hit)    state_d = S_IGNORE;
        else if (ds_low) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      // Abort beats everything; a local ack beats a coinciding timeout.
      S_WAIT: begin
        if (as_n)         state_d = S_IDLE;
        else if (LOC_ACK) state_d = S_RESP;
        else if (expire)  state_d = S_BERR;
      end
      S_RESP, S_BERR, S_IGNORE: if (as_n) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= S_IDLE;
      mclk_sync_q <= 2'b11;
      as_sync_q   <= 2'b11;
      uds_sync_q  <= 2'b11;
      lds_sync_q  <= 2'b11;
      vld_q       <= 2'b00;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      loc_req_q   <= 1'b0;
      loc_we_q    <= 1'b0;
      loc_addr_q  <= '0;
      loc_be_q    <= '0;
      loc_wdata_q <= '0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      dtack_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      mclk_sync_q <= {mclk_sync_q[0], M68K_CLK};
      as_sync_q   <= {as_sync_q[0], M68K_AS_n};
      uds_sync_q  <= {uds_sync_q[0], M68K_UDS_n};
      lds_sync_q  <= {lds_sync_q[0], M68K_LDS_n};
      vld_q       <= {vld_q[0], 1'b1};
      armed_q     <= armed_d;
      loc_req_q   <= issue;
      if (issue) begin
        cnt_q      <= '0;
        loc_we_q   <= ~M68K_RW;
        loc_addr_q <= M68K_A;
        loc_be_q   <= {~uds_sync_q[1], ~lds_sync_q[1]};
        if (!M68K_RW) loc_wdata_q <= M68K_D_IN;
      end else if (state_q == S_WAIT && mclk_fall) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == S_WAIT && state_d == S_RESP && !loc_we_q) d_out_q <= LOC_RDATA;
      // Responses are registered from the next state so they track RESP/BERR exactly.
      dtack_n_q <= (state_d != S_RESP);
      berr_n_q  <= (state_d != S_BERR);
      d_oe_q    <= (state_d == S_RESP) && !loc_we_q;
    end
  end

  assign M68K_D_OUT   = d_out_q;
  assign M68K_D_OE    = d_oe_q;
  assign M68K_DTACK_n = dtack_n_q;
  assign M68K_BERR_n  = berr_n_q;
  assign LOC_REQ      = loc_req_q;
  assign LOC_WE       = loc_we_q;
  assign LOC_ADDR     = loc_addr_q;
  assign LOC_BE       = loc_be_q;
  assign LOC_WDATA    = loc_wdata_q;
  assign dbg_state_o  = state_q;

endmodule
